ps2_host_rx: RTL
================

// Module: ps2_host_rx
// PURPOSE
//  Host-side PS/2 receiver: samples device-driven ps2_clk/ps2_data, deframes 11-bit frames
//  (start, 8 data LSB-first, odd parity, stop), checks them, queues good bytes in a FIFO.
//  Sits between the board PS/2 pins (or keyboard sim model) and the peripheral register block.
//  Device changes data on ps2_clk rising edge; this block samples on ps2_clk falling edge.
// PARAMETERS
//  FIFO_DEPTH      8     received-byte FIFO entries, power of 2, >=2
//  SYNC_STAGES     2     synchronizer flops per PS/2 input, >=2
//  TIMEOUT_CYCLES  4000  clk cycles without ps2_clk falling edge before mid-frame abort (timeout build only)
// PORTS
//  clk          in   1                 system clock
//  reset        in   1                 asynchronous, active-high
//  ps2_clk      in   1                 PS/2 clock from device, asynchronous
//  ps2_data     in   1                 PS/2 data from device, asynchronous
//  rx_valid     out  1                 FIFO non-empty; rx_data holds head byte
//  rx_data      out  8                 FIFO head byte (show-ahead)
//  rx_ack       in   1                 pop head; honoured only when rx_valid=1
//  frame_error  out  1                 1-cycle pulse: bad start/parity/stop or timeout abort
//  overflow     out  1                 1-cycle pulse: good byte dropped, FIFO full
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  entries held
// BEHAVIOUR
//  Reset: all sync flops and edge-detect flop = 1; state IDLE; bit_cnt=0; shift=0; FIFO empty;
//   rx_valid=0, rx_data=0, frame_error=0, overflow=0, fifo_count=0.
//  Sync: SYNC_STAGES flops per input; fall = (clk_prev==1 && clk_sync==0); data sampled = data_sync
//   in the same cycle fall is seen.
//  FSM (advances only on fall):
//   IDLE:   data==0 -> DATA, bit_cnt=0; data==1 -> stay IDLE, no error (glitch ignored).
//   DATA:   shift <= {data, shift[7:1]}; bit_cnt++; after 8th bit -> PARITY.
//   PARITY: latch parity bit -> STOP.
//   STOP:   good = (data==1) && (^{shift,parity}==1); good -> push; else frame_error pulse. -> IDLE.
//  Latency: push/frame_error registered the cycle after the STOP fall detect; rx_valid rises that same
//   cycle when FIFO was empty; rx_data valid simultaneously.
//  FIFO: rd/wr pointers wrap modulo FIFO_DEPTH; fifo_count 0..FIFO_DEPTH.
//   push when full and no pop -> byte dropped, overflow pulse, FIFO unchanged.
//   push and pop same cycle (incl. full) -> both performed, count unchanged, no overflow.
//   rx_ack while empty -> ignored, count stays 0.
//   bad frame never reaches the FIFO.
//  Reset mid-frame: partial frame discarded, FIFO flushed, outputs to reset values immediately.
// CONFIGURATION
//  PS2_RX_TIMEOUT_EN defined: counter reloads on every fall; in DATA/PARITY/STOP, TIMEOUT_CYCLES
//   cycles without fall -> abort to IDLE, partial byte discarded, frame_error pulse once; counter idle in IDLE.
//  Undefined: no counter; FSM waits indefinitely for next falling edge; TIMEOUT_CYCLES unused.
// TESTING
//  1 Frame 0x5A: start 0, data 0,1,0,1,1,0,1,0, parity 1, stop 1 -> rx_valid=1, rx_data=0x5A, count=1.
//  2 Frame 0x00, parity bit 0 -> frame_error pulse, rx_valid stays 0; next frame 0x01 parity 0 -> 0x01 queued.
//  3 Frames 0x00..0x08, no rx_ack -> count=8, one overflow pulse on 9th; pops yield 0x00..0x07, then rx_valid=0.
//  4 FIFO full, rx_ack asserted in push cycle of 0x09 -> no overflow, count=8, head becomes 0x01.
//  5 (PS2_RX_TIMEOUT_EN) start + 3 bits, ps2_clk held 1 for 5000 cycles -> one frame_error pulse,
//    FSM IDLE; following frame 0x12 -> rx_data=0x12.
//  6 Reset asserted after 5 data bits with 2 bytes queued -> count=0, rx_valid=0; next frame 0xF0 received clean.

Source files
------------

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: synchronises ps2_clk/ps2_data, deframes 11-bit frames, queues good bytes.
// Define PS2_RX_TIMEOUT_EN to abort a stalled frame after TIMEOUT_CYCLES clk cycles.
module ps2_host_rx #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          rx_valid,
    output logic [7:0]                    rx_data,
    input  logic                          rx_ack,
    output logic                          frame_error,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   frame_error_q, frame_error_d;
    logic                   overflow_q, overflow_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [7:0]             mem_d [FIFO_DEPTH];

    logic clk_s, data_s, fall, push, timeout, pop, full, wr;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_s;
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;

    // Counts cycles since the last falling edge; held at zero while idle.
    always_comb begin
        tmo_d   = tmo_q;
        timeout = 1'b0;
        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            timeout = 1'b1;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        push          = 1'b0;
        frame_error_d = 1'b0;
        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    parity_d = data_s;
                    state_d  = StStop;
                end
                StStop: begin
                    if (data_s && (^{shift_q, parity_q})) push = 1'b1;
                    else                                  frame_error_d = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (timeout) begin
            state_d       = StIdle;
            frame_error_d = 1'b1;
        end
    end

    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    always_comb begin
        pop        = rx_ack && (count_q != '0);
        full       = (count_q == CntW'(FIFO_DEPTH));
        wr         = push && (!full || pop);
        overflow_d = push && full && !pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;
        if (wr) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (wr && !pop)      count_d = count_q + CntW'(1);
        else if (!wr && pop) count_d = count_q - CntW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q    <= '1;
            data_sync_q   <= '1;
            clk_prev_q    <= 1'b1;
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            clk_prev_q    <= clk_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            frame_error_q <= frame_error_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end

    assign rx_valid    = (count_q != '0);
    assign rx_data     = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;
    assign fifo_count  = count_q;

endmodule
